// File: rtl/rob_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_pkg: shared entry flags and pointer helpers for rob_ptr.   Rev 1.0
// ----------------------------------------------------------------------------
package rob_pkg;

  typedef struct packed {
    logic valid;
    logic completed;
    logic branch;
    logic take;
  } rob_flags_t;

  function automatic int rob_ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int rob_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Single-subtract wrap: valid while ptr < depth and inc <= depth.
  function automatic int rob_wrap_add(input int ptr, input int inc, input int depth);
    int sum;
    sum = ptr + inc;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_retire_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_retire_scan: in-order retire window scan from head, stops at taken branch.
// Rev 1.0
// ----------------------------------------------------------------------------
module rob_retire_scan #(
  parameter int RETIRE_W = 2,
  parameter int XLEN     = 32
) (
  input  logic [RETIRE_W-1:0]                 win_valid,
  input  logic [RETIRE_W-1:0]                 win_completed,
  input  logic [RETIRE_W-1:0]                 win_branch,
  input  logic [RETIRE_W-1:0]                 win_take,
  input  logic [RETIRE_W-1:0][XLEN-1:0]       win_target,
  output logic [RETIRE_W-1:0]                 retire_valid,
  output logic [$clog2(RETIRE_W+1)-1:0]       ret_cnt,
  output logic                                flush,
  output logic [XLEN-1:0]                     flush_pc
);

  localparam int RCNT_W = $clog2(RETIRE_W + 1);

  logic go;

  always_comb begin
    retire_valid = '0;
    ret_cnt      = '0;
    flush        = 1'b0;
    flush_pc     = '0;
    go           = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (go && win_valid[i] && win_completed[i]) begin
        retire_valid[i] = 1'b1;
        ret_cnt         = ret_cnt + RCNT_W'(1);
        if (win_branch[i] && win_take[i]) begin
          flush    = 1'b1;
          flush_pc = win_target[i];
          go       = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_ptr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_ptr: pointer-based reorder buffer; ROB_PERF_EN adds saturating perf counters.
// Rev 1.0
// ----------------------------------------------------------------------------
module rob_ptr
  import rob_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int RETIRE_W   = 2,
  parameter int CDB_W      = 2,
  parameter int TAG_BITS   = 6,
  parameter int XLEN       = 32
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [DISPATCH_W-1:0]                 dis_valid,
  input  logic [DISPATCH_W-1:0][TAG_BITS-1:0]   dis_tag,
  input  logic [DISPATCH_W-1:0][TAG_BITS-1:0]   dis_told,
  input  logic [DISPATCH_W-1:0]                 dis_branch,
  output logic [DISPATCH_W-1:0]                 dispatched,
  output logic [$clog2(DISPATCH_W+1)-1:0]       free_slots,
  input  logic [CDB_W-1:0]                      cdb_valid,
  input  logic [CDB_W-1:0][TAG_BITS-1:0]        cdb_tag,
  input  logic [CDB_W-1:0]                      cdb_take,
  input  logic [CDB_W-1:0][XLEN-1:0]            cdb_target,
  output logic [RETIRE_W-1:0]                   retire_valid,
  output logic [RETIRE_W-1:0][TAG_BITS-1:0]     retire_tag,
  output logic [RETIRE_W-1:0][TAG_BITS-1:0]     retire_told,
  output logic                                  flush,
  output logic [XLEN-1:0]                       flush_pc,
  output logic [DEPTH-1:0]                      squash_valid,
  output logic [DEPTH-1:0][TAG_BITS-1:0]        squash_tag,
`ifdef ROB_PERF_EN
  output logic [31:0]                           perf_retired,
  output logic [31:0]                           perf_flushes,
`endif
  output logic [$clog2(DEPTH+1)-1:0]            count
);

  localparam int PTR_W  = rob_ptr_w(DEPTH);
  localparam int CNT_W  = rob_cnt_w(DEPTH);
  localparam int FREE_W = $clog2(DISPATCH_W + 1);
  localparam int RCNT_W = $clog2(RETIRE_W + 1);

  typedef struct packed {
    rob_flags_t             flags;
    logic [XLEN-1:0]        target;
    logic [TAG_BITS-1:0]    tag;
    logic [TAG_BITS-1:0]    told;
  } rob_entry_t;

  rob_entry_t              entries_q [DEPTH];
  rob_entry_t              entries_d [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [RETIRE_W-1:0]            win_valid, win_completed, win_branch, win_take;
  logic [RETIRE_W-1:0][XLEN-1:0]  win_target;
  logic [RETIRE_W-1:0][PTR_W-1:0] win_idx;
  logic [RCNT_W-1:0]              ret_cnt;
  logic [DEPTH-1:0]               retire_mask;
  logic [FREE_W-1:0]              dis_req, accept;
  logic [PTR_W-1:0]               wr_idx;
  int                             room;

  always_comb begin
    win_idx       = '0;
    win_valid     = '0;
    win_completed = '0;
    win_branch    = '0;
    win_take      = '0;
    win_target    = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      win_idx[i]       = PTR_W'(rob_wrap_add(int'(head_q), i, DEPTH));
      win_valid[i]     = entries_q[win_idx[i]].flags.valid;
      win_completed[i] = entries_q[win_idx[i]].flags.completed;
      win_branch[i]    = entries_q[win_idx[i]].flags.branch;
      win_take[i]      = entries_q[win_idx[i]].flags.take;
      win_target[i]    = entries_q[win_idx[i]].target;
    end
  end

  rob_retire_scan #(
    .RETIRE_W (RETIRE_W),
    .XLEN     (XLEN)
  ) u_scan (
    .win_valid     (win_valid),
    .win_completed (win_completed),
    .win_branch    (win_branch),
    .win_take      (win_take),
    .win_target    (win_target),
    .retire_valid  (retire_valid),
    .ret_cnt       (ret_cnt),
    .flush         (flush),
    .flush_pc      (flush_pc)
  );

  // Everything left valid that is not retiring this cycle is younger than the flushing branch.
  always_comb begin
    retire_mask  = '0;
    retire_tag   = '0;
    retire_told  = '0;
    squash_valid = '0;
    squash_tag   = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (retire_valid[i]) begin
        retire_mask[win_idx[i]] = 1'b1;
        retire_tag[i]           = entries_q[win_idx[i]].tag;
        retire_told[i]          = entries_q[win_idx[i]].told;
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      squash_valid[j] = flush && entries_q[j].flags.valid && !retire_mask[j];
      squash_tag[j]   = squash_valid[j] ? entries_q[j].tag : '0;
    end
  end

  always_comb begin
    room       = DEPTH - int'(count_q);
    free_slots = (room < DISPATCH_W) ? FREE_W'(room) : FREE_W'(DISPATCH_W);
    dis_req    = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      dis_req = dis_req + FREE_W'(dis_valid[k]);
    end
    accept = (dis_req < free_slots) ? dis_req : free_slots;
    if (flush || !reset) begin
      accept = '0;
    end
    dispatched = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      dispatched[k] = (k < int'(accept));
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_idx    = '0;
    if (flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        entries_d[j].flags.valid     = 1'b0;
        entries_d[j].flags.completed = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Ascending port order lets the highest matching port win.
      for (int j = 0; j < DEPTH; j++) begin
        for (int p = 0; p < CDB_W; p++) begin
          if (entries_q[j].flags.valid && cdb_valid[p] && (entries_q[j].tag == cdb_tag[p])) begin
            entries_d[j].flags.completed = 1'b1;
            entries_d[j].flags.take      = cdb_take[p];
            entries_d[j].target          = cdb_target[p];
          end
        end
        if (retire_mask[j]) begin
          entries_d[j].flags.valid = 1'b0;
        end
      end
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (dispatched[k]) begin
          wr_idx = PTR_W'(rob_wrap_add(int'(tail_q), k, DEPTH));
          entries_d[wr_idx].flags.valid     = 1'b1;
          entries_d[wr_idx].flags.completed = 1'b0;
          entries_d[wr_idx].flags.branch    = dis_branch[k];
          entries_d[wr_idx].flags.take      = 1'b0;
          entries_d[wr_idx].target          = '0;
          entries_d[wr_idx].tag             = dis_tag[k];
          entries_d[wr_idx].told            = dis_told[k];
        end
      end
      head_d  = PTR_W'(rob_wrap_add(int'(head_q), int'(ret_cnt), DEPTH));
      tail_d  = PTR_W'(rob_wrap_add(int'(tail_q), int'(accept), DEPTH));
      count_d = count_q + CNT_W'(accept) - CNT_W'(ret_cnt);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        entries_q[j] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign count = count_q;

`ifdef ROB_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic [32:0] perf_sum;

  always_comb begin
    perf_sum       = {1'b0, perf_retired_q} + 33'(ret_cnt);
    perf_retired_d = perf_sum[32] ? '1 : perf_sum[31:0];
    perf_flushes_d = perf_flushes_q;
    if (flush && (perf_flushes_q != '1)) begin
      perf_flushes_d = perf_flushes_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_ptr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rob_ptr: directed + random stimulus against an in-order queue model of the ROB.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rob_ptr;

  localparam int D  = 8;
  localparam int DW = 2;
  localparam int RW = 2;
  localparam int CW = 2;
  localparam int TB = 6;
  localparam int XL = 32;

  logic                 clk;
  logic                 reset;
  logic [DW-1:0]        dis_valid;
  logic [DW-1:0][TB-1:0] dis_tag;
  logic [DW-1:0][TB-1:0] dis_told;
  logic [DW-1:0]        dis_branch;
  logic [DW-1:0]        dispatched;
  logic [1:0]           free_slots;
  logic [CW-1:0]        cdb_valid;
  logic [CW-1:0][TB-1:0] cdb_tag;
  logic [CW-1:0]        cdb_take;
  logic [CW-1:0][XL-1:0] cdb_target;
  logic [RW-1:0]        retire_valid;
  logic [RW-1:0][TB-1:0] retire_tag;
  logic [RW-1:0][TB-1:0] retire_told;
  logic                 flush;
  logic [XL-1:0]        flush_pc;
  logic [D-1:0]         squash_valid;
  logic [D-1:0][TB-1:0] squash_tag;
  logic [3:0]           count;

  rob_ptr #(
    .DEPTH(D), .DISPATCH_W(DW), .RETIRE_W(RW), .CDB_W(CW), .TAG_BITS(TB), .XLEN(XL)
  ) dut (
    .clock(clk), .reset(reset),
    .dis_valid(dis_valid), .dis_tag(dis_tag), .dis_told(dis_told), .dis_branch(dis_branch),
    .dispatched(dispatched), .free_slots(free_slots),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_take(cdb_take), .cdb_target(cdb_target),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_told(retire_told),
    .flush(flush), .flush_pc(flush_pc),
    .squash_valid(squash_valid), .squash_tag(squash_tag),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [TB-1:0] tag;
    logic [TB-1:0] told;
    bit            br;
    bit            done;
    bit            take;
    logic [XL-1:0] tgt;
  } ment_t;

  ment_t mq[$];
  int    mh;

  int    vectors;
  int    miscompares;

  int            e_free, e_nret, e_acc;
  bit            e_flush;
  logic [XL-1:0] e_pc;
  logic [D-1:0]  e_sq;
  logic [TB-1:0] e_sqtag [D];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic idle();
    dis_valid  = '0;
    dis_tag    = '0;
    dis_told   = '0;
    dis_branch = '0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    cdb_take   = '0;
    cdb_target = '0;
  endtask

  // Expected outputs from the in-order queue: head-window retire rule, flush, squash and accept.
  task automatic predict();
    int n;
    e_free  = ((D - mq.size()) < DW) ? (D - mq.size()) : DW;
    e_nret  = 0;
    e_flush = 1'b0;
    e_pc    = '0;
    for (int i = 0; i < RW && i < mq.size(); i++) begin
      if (!mq[i].done) break;
      e_nret++;
      if (mq[i].br && mq[i].take) begin
        e_flush = 1'b1;
        e_pc    = mq[i].tgt;
        break;
      end
    end
    n = 0;
    for (int k = 0; k < DW; k++) n += int'(dis_valid[k]);
    e_acc = e_flush ? 0 : ((n < e_free) ? n : e_free);
    e_sq  = '0;
    for (int s = 0; s < D; s++) e_sqtag[s] = '0;
    if (e_flush) begin
      for (int q = e_nret; q < mq.size(); q++) begin
        e_sq[(mh + q) % D]    = 1'b1;
        e_sqtag[(mh + q) % D] = mq[q].tag;
      end
    end
  endtask

  task automatic compare();
    chk("free_slots", 64'(free_slots), 64'(e_free));
    chk("count", 64'(count), 64'(mq.size()));
    chk("dispatched", 64'(dispatched), 64'((1 << e_acc) - 1));
    chk("retire_valid", 64'(retire_valid), 64'((1 << e_nret) - 1));
    for (int i = 0; i < e_nret; i++) begin
      chk("retire_tag", 64'(retire_tag[i]), 64'(mq[i].tag));
      chk("retire_told", 64'(retire_told[i]), 64'(mq[i].told));
    end
    chk("flush", 64'(flush), 64'(e_flush));
    if (e_flush) chk("flush_pc", 64'(flush_pc), 64'(e_pc));
    chk("squash_valid", 64'(squash_valid), 64'(e_sq));
    for (int s = 0; s < D; s++) begin
      if (e_sq[s]) chk("squash_tag", 64'(squash_tag[s]), 64'(e_sqtag[s]));
    end
  endtask

  task automatic update();
    if (e_flush) begin
      mq.delete();
      mh = 0;
    end else begin
      for (int j = 0; j < mq.size(); j++) begin
        for (int p = 0; p < CW; p++) begin
          if (cdb_valid[p] && (mq[j].tag == cdb_tag[p])) begin
            mq[j].done = 1'b1;
            mq[j].take = cdb_take[p];
            mq[j].tgt  = cdb_target[p];
          end
        end
      end
      for (int r = 0; r < e_nret; r++) void'(mq.pop_front());
      mh = (mh + e_nret) % D;
      for (int k = 0; k < e_acc; k++) begin
        mq.push_back('{tag: dis_tag[k], told: dis_told[k], br: dis_branch[k],
                       done: 1'b0, take: 1'b0, tgt: '0});
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    predict();
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic disp2(input logic [1:0] v, input int t0, input int o0, input bit b0,
                       input int t1, input int o1, input bit b1);
    dis_valid     = v;
    dis_tag[0]    = TB'(t0);
    dis_told[0]   = TB'(o0);
    dis_branch[0] = b0;
    dis_tag[1]    = TB'(t1);
    dis_told[1]   = TB'(o1);
    dis_branch[1] = b1;
  endtask

  task automatic cdb(input int p, input int t, input bit tk, input logic [XL-1:0] tg);
    cdb_valid[p]  = 1'b1;
    cdb_tag[p]    = TB'(t);
    cdb_take[p]   = tk;
    cdb_target[p] = tg;
  endtask

  task automatic rand_inputs();
    int n;
    idle();
    n = $urandom_range(0, 2);
    dis_valid = (n == 0) ? 2'b00 : ((n == 1) ? 2'b01 : 2'b11);
    for (int k = 0; k < DW; k++) begin
      dis_tag[k]    = TB'($urandom_range(0, 15));
      dis_told[k]   = TB'($urandom);
      dis_branch[k] = ($urandom_range(0, 3) == 0);
    end
    for (int p = 0; p < CW; p++) begin
      cdb_valid[p]  = 1'($urandom_range(0, 1));
      cdb_tag[p]    = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                      : TB'($urandom_range(0, 15));
      cdb_take[p]   = ($urandom_range(0, 3) == 0);
      cdb_target[p] = $urandom;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mh          = 0;
    idle();
    reset = 1'b0;
    dis_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_free_slots", 64'(free_slots), 64'd2);
    chk("rst_dispatched", 64'(dispatched), 64'd0);
    chk("rst_retire_valid", 64'(retire_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_squash_valid", 64'(squash_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Fill to full, then one blocked dispatch.
    for (int c = 0; c < 4; c++) begin
      disp2(2'b11, 10 + 2 * c, 40 + 2 * c, 1'b0, 11 + 2 * c, 41 + 2 * c, 1'b0);
      cycle();
    end
    disp2(2'b11, 30, 31, 1'b0, 32, 33, 1'b0);
    #1;
    chk("full_count", 64'(count), 64'd8);
    chk("full_free_slots", 64'(free_slots), 64'd0);
    chk("full_dispatched", 64'(dispatched), 64'd0);
    cycle();

    // Drain; tail and head both wrap through slot 7 -> 0.
    for (int c = 0; c < 4; c++) begin
      idle();
      cdb(0, 10 + 2 * c, 1'b0, '0);
      cdb(1, 11 + 2 * c, 1'b0, '0);
      cycle();
    end
    idle();
    cycle();
    cycle();
    #1;
    chk("drain_count", 64'(count), 64'd0);

    // Out-of-order completion holds retire until the head completes.
    disp2(2'b11, 1, 11, 1'b0, 2, 12, 1'b0);
    cycle();
    idle();
    cdb(0, 2, 1'b0, '0);
    cycle();
    idle();
    cdb(1, 1, 1'b0, '0);
    #1;
    chk("ooo_retire_hold", 64'(retire_valid), 64'd0);
    cycle();
    idle();
    #1;
    chk("ooo_retire_valid", 64'(retire_valid), 64'd3);
    chk("ooo_retire_told0", 64'(retire_told[0]), 64'd11);
    chk("ooo_retire_told1", 64'(retire_told[1]), 64'd12);
    cycle();

    // Taken branch at head: flush with dispatch and CDB traffic on the same cycle.
    disp2(2'b01, 3, 13, 1'b1, 0, 0, 1'b0);
    cycle();
    disp2(2'b11, 4, 14, 1'b0, 5, 15, 1'b0);
    cycle();
    idle();
    cdb(0, 4, 1'b0, '0);
    cdb(1, 5, 1'b0, '0);
    cycle();
    idle();
    cdb(0, 3, 1'b1, 32'h100);
    cycle();
    idle();
    disp2(2'b11, 6, 16, 1'b0, 7, 17, 1'b0);
    cdb(0, 4, 1'b1, 32'h55);
    cdb(1, 5, 1'b1, 32'h66);
    #1;
    chk("br_flush", 64'(flush), 64'd1);
    chk("br_flush_pc", 64'(flush_pc), 64'h100);
    chk("br_retire_valid", 64'(retire_valid), 64'd1);
    chk("br_retire_tag", 64'(retire_tag[0]), 64'd3);
    chk("br_dispatched", 64'(dispatched), 64'd0);
    chk("br_squash_valid", 64'(squash_valid), 64'h18);
    chk("br_squash_tag3", 64'(squash_tag[3]), 64'd4);
    chk("br_squash_tag4", 64'(squash_tag[4]), 64'd5);
    cycle();
    idle();
    #1;
    chk("br_post_count", 64'(count), 64'd0);
    cycle();

    for (int c = 0; c < 2500; c++) begin
      rand_inputs();
      cycle();
    end

    // Asynchronous reset in the middle of traffic.
    for (int c = 0; c < 5; c++) begin
      rand_inputs();
      cycle();
    end
    rand_inputs();
    dis_valid = 2'b11;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_free_slots", 64'(free_slots), 64'd2);
    chk("mid_rst_dispatched", 64'(dispatched), 64'd0);
    chk("mid_rst_retire_valid", 64'(retire_valid), 64'd0);
    chk("mid_rst_flush", 64'(flush), 64'd0);
    chk("mid_rst_squash_valid", 64'(squash_valid), 64'd0);
    mq.delete();
    mh = 0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    disp2(2'b11, 20, 40, 1'b1, 21, 41, 1'b0);
    cycle();
    idle();
    cdb(0, 20, 1'b1, 32'h200);
    cycle();
    idle();
    #1;
    chk("post_rst_flush_pc", 64'(flush_pc), 64'h200);
    chk("post_rst_squash_valid", 64'(squash_valid), 64'h02);
    chk("post_rst_squash_tag1", 64'(squash_tag[1]), 64'd21);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
